// File: rtl/noob_rr_arb.sv
// noob_rr_arb -- registered round-robin arbiter with bounded grant hold.
//
// Shares one resource among N requesters. A grant, once issued, stays with
// its owner while the owner keeps requesting. When another requester is
// waiting, the owner is limited to MAX_HOLD consecutive grant cycles.
// Ownership then moves to the next requester in round-robin order.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   req        in   N    level-sensitive request vector
//   grant      out  N    registered one-hot grant, zero when idle
//   grant_vld  out  1    high while a grant is held
//   grant_id   out  IDW  index of the granted requester, zero when idle
module noob_rr_arb #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 4,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_vld,
  output logic [IDW-1:0] grant_id
);

  // The hold counter needs at least one bit even when MAX_HOLD is 1.
  localparam int             CW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST    = IDW'(N - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] own_q, own_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           vld_q, vld_d;
  logic [IDW-1:0] id_q, id_d;

  // Index increment modulo N.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x);
    return (x == LAST) ? '0 : x + IDW'(1);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scan start, start+1, ... (mod N); returns {found, index of first set bit}.
  function automatic logic [IDW:0] search(input logic [N-1:0]   r,
                                          input logic [IDW-1:0] start);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] cur;
    found = 1'b0;
    idx   = '0;
    cur   = start;
    for (int k = 0; k < N; k++) begin
      if (!found && r[cur]) begin
        found = 1'b1;
        idx   = cur;
      end
      cur = wrap_inc(cur);
    end
    return {found, idx};
  endfunction

  logic [N-1:0] others;
  logic [IDW:0] sr;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    others  = req & ~onehot(own_q);
    sr      = '0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          sr      = search(req, ptr_q);
          state_d = BUSY;
          own_d   = sr[IDW-1:0];
          cnt_d   = '0;
          ptr_d   = wrap_inc(sr[IDW-1:0]);
        end
      end
      BUSY: begin
        if (req[own_q]) begin
          if (~|others || cnt_q < CNT_MAX) begin
            if (cnt_q < CNT_MAX) cnt_d = cnt_q + CW'(1);
          end else begin
            // Hold expired under contention: a winner among the others exists.
            sr    = search(others, wrap_inc(own_q));
            own_d = sr[IDW-1:0];
            cnt_d = '0;
            ptr_d = wrap_inc(sr[IDW-1:0]);
          end
        end else begin
          sr = search(req, wrap_inc(own_q));
          if (sr[IDW]) begin
            own_d = sr[IDW-1:0];
            cnt_d = '0;
            ptr_d = wrap_inc(sr[IDW-1:0]);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state values so they change
    // exactly at the deciding edge, with no extra cycle of latency.
    vld_d   = (state_d == BUSY);
    grant_d = vld_d ? onehot(own_d) : '0;
    id_d    = vld_d ? own_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
    end
  end

  assign grant     = grant_q;
  assign grant_vld = vld_q;
  assign grant_id  = id_q;

endmodule
